regbank_wr_arbiter: RTL and testbench
=====================================

Name: regbank_wr_arbiter

Overview:
- Shares the register bank's single general write port (wr_reg/wr_data/wr_en) among NREQ writeback requesters (e.g. ALU result, memory load, status-flag update).
- Owns the bank's PC update port (pc_inc/pc_data_in).
- Round-robin arbitration with valid/ready handshakes and one registered cycle of latency.
- Guarantees a general write to r0 (PC) never coincides with a PC update.

Parameters:
- NREQ, 3, number of write requesters (2..8)
- DW, 16, register data width
- RW, 4, register index width
- PC_IDX, 0, register index holding the PC

Ports:
- clk, input, 1, system clock
- rst, input, 1, synchronous active-high reset
- hold, input, 1, freeze: no new grants, no pc_ack, while high
- req_valid, input, NREQ, requester i has a pending write
- req_reg, input, NREQ*RW, packed target index; requester i at bits [i*RW +: RW]
- req_data, input, NREQ*DW, packed write data; requester i at bits [i*DW +: DW]
- req_ready, output, NREQ, one-hot grant, combinational; transfer when valid&ready
- pc_req, input, 1, control unit requests PC update
- pc_next, input, DW, new PC value
- pc_ack, output, 1, PC request accepted this cycle, combinational
- wr_reg, output, RW, to bank wr_reg
- wr_data, output, DW, to bank wr_data
- wr_en, output, 1, to bank wr_en
- pc_inc, output, 1, to bank pc_inc
- pc_data, output, DW, to bank pc_data_in
- last_gnt, output, 3, index of the most recently granted requester (debug/verification)

Behaviour:
Reset (rst sampled high at posedge):
- wr_en=0, wr_reg=0, wr_data=0, pc_inc=0, pc_data=0.
- Round-robin pointer last_gnt=NREQ-1, so requester 0 has first priority.
- While rst is high: req_ready=0, pc_ack=0.
- Reset mid-transfer: the handshake in the reset cycle is discarded; the requester must re-present.

PC path:
- pc_ack = pc_req & ~hold & ~rst.
- On an accepted cycle T: at the posedge ending T, pc_inc<=1 and pc_data<=pc_next. pc_inc is then high for exactly one cycle per accept.
- Otherwise pc_inc<=0 and pc_data holds its value.

General writes, arbitration in cycle T (combinational):
- Eligible(i) = req_valid[i] & ~(pc_req & req_reg[i]==PC_IDX).
- Search order: last_gnt+1, last_gnt+2, ... modulo NREQ. The first eligible requester wins.
- If ~hold & ~rst and a winner exists: req_ready[winner]=1, all other bits 0.
- At the posedge: wr_en<=1, wr_reg/wr_data<=winner's fields, last_gnt<=winner.
- Otherwise: wr_en<=0, wr_reg/wr_data hold, last_gnt holds.

Latency and rate:
- Latency: a handshake at cycle T is written by the bank at the posedge ending T+1.
- Throughput: one general write plus one PC update per cycle.

PC collision rule:
- A request targeting PC_IDX is ineligible in any cycle pc_req is high, so pc_inc and a wr_en to PC_IDX are never high together.
- The deferred requester keeps valid high and is retried when pc_req drops.
- Other eligible requesters may win in its place.

Other rules:
- Ineligible requesters are skipped without advancing past them; the pointer moves only to the actual winner. Starvation-free when pc_req is not held permanently.
- Requesters must hold valid, reg and data stable until ready. Dropping valid without a handshake is permitted and simply withdraws the request.
- hold=1: all req_ready=0, pc_ack=0, wr_en<=0, pc_inc<=0, pointer frozen.
- Simultaneous writes from different requesters to the same register are serialized in grant order. The later grant's data ends up in the register.

Test Plan:
1. Reset: assert rst for 2 cycles with all req_valid=1 -> req_ready=000, wr_en=0, pc_inc=0. After release, first grant goes to req0.
2. Round-robin: req_valid=111 held; req0/1/2 target r4/r5/r6 with data 0x1111/0x2222/0x3333 -> wr_en=1 on consecutive cycles with wr_reg 4,5,6,4..., one cycle after each ready, data matching.
3. PC collision: req1 targets r0 with data 0xBEEF; pc_req=1 with pc_next=0x0102 for 3 cycles.
   -> req_ready[1]=0 during those cycles; pc_inc=1 with pc_data=0x0102 each following cycle; no wr_en to r0.
   -> Once pc_req drops, req1 is granted and wr_reg=0, wr_data=0xBEEF the next cycle.
4. Collision with alternate: the scenario 3 setup plus req2 valid to r7 -> req2 granted during pc_req; last_gnt=2; req1 is granted after pc_req drops.
5. Hold: hold=1 for 4 cycles with all valid -> no ready, no pc_ack, wr_en=0. On release, the grant resumes at last_gnt+1.
6. Mid-operation reset: rst pulsed in the same cycle as req0 valid&ready -> wr_en stays 0 next cycle and last_gnt=NREQ-1 afterwards.

Source files
------------

// File: rtl/regbank_wr_arbiter.sv
// Purpose : round-robin arbiter sharing the register bank's general write port
//           among NREQ writeback requesters, and owner of the bank's PC update port.
// Latency : a handshake in cycle T is presented to the bank during cycle T+1
//           (registered outputs, so the bank writes at the posedge ending T+1).
// Backpressure: req_ready is one-hot and combinational; hold or rst drop every
//           ready and pc_ack. A requester aimed at PC_IDX is held off while pc_req is high.
// Ports   : clk/rst (sync, active-high), hold (freeze);
//           req_valid/req_reg/req_data/req_ready - packed per-requester write channel;
//           pc_req/pc_next/pc_ack - control-unit PC update channel;
//           wr_reg/wr_data/wr_en, pc_inc/pc_data - registered bank-side ports;
//           last_gnt - index of the most recent general-write winner.
module regbank_wr_arbiter #(
  parameter int NREQ   = 3,
  parameter int DW     = 16,
  parameter int RW     = 4,
  parameter int PC_IDX = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               hold,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*RW-1:0] req_reg,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  input  logic               pc_req,
  input  logic [DW-1:0]      pc_next,
  output logic               pc_ack,
  output logic [RW-1:0]      wr_reg,
  output logic [DW-1:0]      wr_data,
  output logic               wr_en,
  output logic               pc_inc,
  output logic [DW-1:0]      pc_data,
  output logic [2:0]         last_gnt
);

  // Eligibility padded to 8 bits so a 3-bit index selects it without width games.
  logic [7:0]    elig;
  logic [2:0]    winner;
  logic          found;
  logic          grant;
  logic [RW-1:0] sel_reg;
  logic [DW-1:0] sel_data;

  // A write to the PC register is deferred while a PC update is requested, so
  // the bank never sees pc_inc and a general write to PC_IDX in the same cycle.
  always_comb begin
    elig = '0;
    for (int i = 0; i < NREQ; i++) begin
      elig[i] = req_valid[i] & ~(pc_req & (req_reg[i*RW +: RW] == RW'(PC_IDX)));
    end
  end

  // Search starts just after the last winner; skipped (ineligible) requesters
  // do not move the pointer, only the actual winner does.
  always_comb begin
    logic [2:0] cand;
    found  = 1'b0;
    winner = last_gnt;
    cand   = last_gnt;
    for (int k = 0; k < NREQ; k++) begin
      cand = (cand == 3'(NREQ - 1)) ? 3'd0 : cand + 3'd1;
      if (!found && elig[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  assign grant  = found & ~hold & ~rst;
  assign pc_ack = pc_req & ~hold & ~rst;

  always_comb begin
    req_ready = '0;
    sel_reg   = '0;
    sel_data  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (winner == 3'(i)) begin
        req_ready[i] = grant;
        sel_reg      = req_reg[i*RW +: RW];
        sel_data     = req_data[i*DW +: DW];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en    <= 1'b0;
      wr_reg   <= '0;
      wr_data  <= '0;
      pc_inc   <= 1'b0;
      pc_data  <= '0;
      last_gnt <= 3'(NREQ - 1);
    end else begin
      pc_inc <= pc_ack;
      if (pc_ack) begin
        pc_data <= pc_next;
      end
      wr_en <= grant;
      if (grant) begin
        wr_reg   <= sel_reg;
        wr_data  <= sel_data;
        last_gnt <= winner;
      end
    end
  end

endmodule

// File: tb/tb_regbank_wr_arbiter.sv
// Purpose : self-checking bench for regbank_wr_arbiter (NREQ=3, DW=16, RW=4, PC_IDX=0).
// Latency : expected bank-side values are queued each cycle and compared one cycle later.
// Backpressure: requesters keep their fields stable until ready, may withdraw valid.
module tb_regbank_wr_arbiter;

  localparam int NREQ = 3;
  localparam int DW   = 16;
  localparam int RW   = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic               hold;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*RW-1:0] req_reg;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic               pc_req;
  logic [DW-1:0]      pc_next;
  logic               pc_ack;
  logic [RW-1:0]      wr_reg;
  logic [DW-1:0]      wr_data;
  logic               wr_en;
  logic               pc_inc;
  logic [DW-1:0]      pc_data;
  logic [2:0]         last_gnt;

  logic [RW-1:0] rr [NREQ];
  logic [DW-1:0] rd [NREQ];

  always #5 clk = ~clk;

  always_comb begin
    req_reg  = '0;
    req_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_reg[i*RW +: RW]  = rr[i];
      req_data[i*DW +: DW] = rd[i];
    end
  end

  regbank_wr_arbiter #(.NREQ(NREQ), .DW(DW), .RW(RW), .PC_IDX(0)) dut (
    .clk(clk), .rst(rst), .hold(hold),
    .req_valid(req_valid), .req_reg(req_reg), .req_data(req_data), .req_ready(req_ready),
    .pc_req(pc_req), .pc_next(pc_next), .pc_ack(pc_ack),
    .wr_reg(wr_reg), .wr_data(wr_data), .wr_en(wr_en),
    .pc_inc(pc_inc), .pc_data(pc_data), .last_gnt(last_gnt)
  );

  typedef struct {
    logic          wr_en;
    logic [RW-1:0] wr_reg;
    logic [DW-1:0] wr_data;
    logic          pc_inc;
    logic [DW-1:0] pc_data;
    logic [2:0]    lg;
  } snap_t;

  snap_t q[$];

  int n_chk  = 0;
  int n_fail = 0;

  // Reference state of the bank-side registers and round-robin pointer.
  logic          m_wr_en   = 1'b0;
  logic [RW-1:0] m_wr_reg  = '0;
  logic [DW-1:0] m_wr_data = '0;
  logic          m_pc_inc  = 1'b0;
  logic [DW-1:0] m_pc_data = '0;
  int            mptr      = NREQ - 1;
  logic [NREQ-1:0] last_rdy = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Runs at the negedge: first compares the registered outputs against the
  // snapshot queued last cycle, then checks this cycle's handshake outputs and
  // queues the snapshot the next posedge should produce.
  task automatic check_cycle();
    snap_t           e;
    logic [NREQ-1:0] elig;
    logic [NREQ-1:0] exp_rdy;
    logic            exp_ack;
    int              win;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("wr_en",    32'(wr_en),    32'(e.wr_en));
      chk("wr_reg",   32'(wr_reg),   32'(e.wr_reg));
      chk("wr_data",  32'(wr_data),  32'(e.wr_data));
      chk("pc_inc",   32'(pc_inc),   32'(e.pc_inc));
      chk("pc_data",  32'(pc_data),  32'(e.pc_data));
      chk("last_gnt", 32'(last_gnt), 32'(e.lg));
    end
    chk("pc_wr_collision", 32'(pc_inc & wr_en & (wr_reg == '0)), 32'd0);

    elig = '0;
    for (int i = 0; i < NREQ; i++) begin
      elig[i] = req_valid[i] && !(pc_req && rr[i] == '0);
    end
    win = -1;
    if (!rst && !hold) begin
      for (int k = 1; k <= NREQ; k++) begin
        int c;
        c = (mptr + k) % NREQ;
        if (win < 0 && elig[c]) win = c;
      end
    end
    exp_rdy = (win >= 0) ? NREQ'(1 << win) : '0;
    exp_ack = pc_req && !hold && !rst;
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    chk("pc_ack",    32'(pc_ack),    32'(exp_ack));
    last_rdy = exp_rdy;

    if (rst) begin
      m_wr_en = 1'b0; m_wr_reg = '0; m_wr_data = '0;
      m_pc_inc = 1'b0; m_pc_data = '0; mptr = NREQ - 1;
    end else begin
      m_wr_en = (win >= 0);
      if (win >= 0) begin
        m_wr_reg  = rr[win];
        m_wr_data = rd[win];
        mptr      = win;
      end
      m_pc_inc = exp_ack;
      if (exp_ack) m_pc_data = pc_next;
    end
    e.wr_en = m_wr_en; e.wr_reg = m_wr_reg; e.wr_data = m_wr_data;
    e.pc_inc = m_pc_inc; e.pc_data = m_pc_data; e.lg = 3'(mptr);
    q.push_back(e);
  endtask

  task automatic step();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [2:0] lg_saved;
    rst = 1'b1; hold = 1'b0; pc_req = 1'b0; pc_next = '0;
    req_valid = '1;
    rr[0] = 4'd4; rd[0] = 16'h1111;
    rr[1] = 4'd5; rd[1] = 16'h2222;
    rr[2] = 4'd6; rd[2] = 16'h3333;
    @(posedge clk); #1;

    // Reset with everything valid, then first grant goes to requester 0.
    step(); step();
    chk("t1_wr_en_rst", 32'(wr_en), 32'd0);
    rst = 1'b0;
    step();
    chk("t1_first_grant", 32'(last_gnt), 32'd0);
    chk("t1_first_reg", 32'(wr_reg), 32'd4);

    // Round-robin over all three.
    repeat (6) step();

    // PC collision: requester 1 targets r0 while a PC update is pending.
    req_valid = 3'b010; rr[1] = 4'd0; rd[1] = 16'hBEEF;
    pc_req = 1'b1; pc_next = 16'h0102;
    repeat (3) step();
    chk("t3_pc_inc", 32'(pc_inc), 32'd1);
    chk("t3_pc_data", 32'(pc_data), 32'h0102);
    pc_req = 1'b0;
    step();
    chk("t3_wr_en", 32'(wr_en), 32'd1);
    chk("t3_wr_reg", 32'(wr_reg), 32'd0);
    chk("t3_wr_data", 32'(wr_data), 32'hBEEF);

    // Same collision with an alternate requester available.
    req_valid = 3'b110; rr[2] = 4'd7;
    pc_req = 1'b1; pc_next = 16'h0A0B;
    repeat (3) step();
    chk("t4_alt_gnt", 32'(last_gnt), 32'd2);
    chk("t4_alt_reg", 32'(wr_reg), 32'd7);
    pc_req = 1'b0;
    step();
    chk("t4_deferred_gnt", 32'(last_gnt), 32'd1);

    // Hold freezes everything; grant resumes after the frozen pointer.
    req_valid = 3'b111; rr[1] = 4'd5; pc_req = 1'b1; hold = 1'b1;
    lg_saved = last_gnt;
    repeat (4) step();
    chk("t5_hold_ptr", 32'(last_gnt), 32'(lg_saved));
    chk("t5_hold_wr_en", 32'(wr_en), 32'd0);
    hold = 1'b0; pc_req = 1'b0;
    step();
    chk("t5_resume", 32'(last_gnt), 32'((lg_saved + 3'd1) % 3'(NREQ)));

    // Reset pulse while requester 0 is presenting.
    req_valid = 3'b001;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_ptr", 32'(last_gnt), 32'(NREQ - 1));
    chk("t6_wr_en", 32'(wr_en), 32'd0);
    step();

    // Randomised traffic, keeping fields stable until each handshake.
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] || last_rdy[i]) begin
          req_valid[i] = ($urandom_range(0, 3) != 0);
          rr[i] = RW'($urandom_range(0, 3));
          rd[i] = DW'($urandom);
        end else if ($urandom_range(0, 15) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      pc_req  = ($urandom_range(0, 2) == 0);
      pc_next = DW'($urandom);
      hold    = ($urandom_range(0, 7) == 0);
      rst     = ($urandom_range(0, 49) == 0);
      step();
    end
    rst = 1'b0; hold = 1'b0; pc_req = 1'b0; req_valid = '0;
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
